// File: rtl/ppl_stage_buf.sv
// ---------------------------------------------------------------------------
// ppl_stage_buf
// Parametrised pipeline stage register for the in-order core. It carries an
// opaque data bundle and a control bundle between stages with a valid/ready
// handshake. A stall holds the contents in place. A flush squashes every held
// entry so that no side effects leak downstream.
//
// With SKID=1 the stage holds a main entry M, which drives the outputs, and a
// skid entry S. in_ready then comes straight from a register, so the backward
// stall path is cut at this stage. With SKID=0 there is only M, and in_ready
// is combinational from out_ready.
//
// Ports:
//   clk        stage clock
//   rst        asynchronous, active-high reset
//   flush      squash all held entries (branch / interrupt redirect)
//   in_valid   upstream entry valid
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream data bundle  [DATA_W]
//   in_ctrl    upstream control bundle [CTRL_W]
//   out_valid  head entry valid
//   out_ready  downstream accepts head; 0 = stall
//   out_data   head data bundle [DATA_W]
//   out_ctrl   head control bundle, zero whenever out_valid is low [CTRL_W]
//   level      number of entries held (0..2)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module ppl_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              mValid_q, mValid_d;
    logic [DATA_W-1:0] mData_q,  mData_d;
    logic [CTRL_W-1:0] mCtrl_q,  mCtrl_d;
    logic              sValid_q, sValid_d;
    logic [DATA_W-1:0] sData_q,  sData_d;
    logic [CTRL_W-1:0] sCtrl_q,  sCtrl_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;

    logic inFire;
    logic outFire;

    // With a skid entry, in_ready depends only on whether S is occupied. That
    // keeps out_ready off the backward path. Without a skid entry, the stage
    // can take a new entry whenever M is empty or M is leaving this cycle.
    assign in_ready  = (SKID != 0) ? ~sValid_q : (~mValid_q | out_ready);
    assign inFire    = in_valid & in_ready;
    assign outFire   = mValid_q & out_ready;

    assign out_valid = mValid_q;
    assign out_data  = mData_q;
    // A bubble must never carry control bits. M_ctrl is cleared whenever M
    // goes invalid, and the gate here makes that guarantee explicit.
    assign out_ctrl  = mValid_q ? mCtrl_q : '0;
    assign level     = {1'b0, mValid_q} + {1'b0, sValid_q};
    assign stall_cnt = stallCnt_q;

    // Next-state for the M/S entries. Flush wins over every handshake: any
    // entry accepted in the flush cycle is dropped, and a head leaving in the
    // same cycle has already been taken downstream. Data is kept on
    // invalidation because only valid and ctrl matter for a bubble.
    always_comb begin
        mValid_d = mValid_q;
        mData_d  = mData_q;
        mCtrl_d  = mCtrl_q;
        sValid_d = sValid_q;
        sData_d  = sData_q;
        sCtrl_d  = sCtrl_q;

        if (flush) begin
            mValid_d = 1'b0;
            mCtrl_d  = '0;
            sValid_d = 1'b0;
            sCtrl_d  = '0;
        end else if (SKID != 0) begin
            if (outFire) begin
                if (sValid_q) begin
                    // Skid entry moves up. in_ready was low, so no new entry
                    // can arrive in this cycle.
                    mValid_d = 1'b1;
                    mData_d  = sData_q;
                    mCtrl_d  = sCtrl_q;
                    sValid_d = 1'b0;
                    sCtrl_d  = '0;
                end else if (inFire) begin
                    mValid_d = 1'b1;
                    mData_d  = in_data;
                    mCtrl_d  = in_ctrl;
                end else begin
                    mValid_d = 1'b0;
                    mCtrl_d  = '0;
                end
            end else if (inFire) begin
                if (!mValid_q) begin
                    mValid_d = 1'b1;
                    mData_d  = in_data;
                    mCtrl_d  = in_ctrl;
                end else begin
                    // Head is stalled, so park the new entry in S. in_ready
                    // falls on the next cycle.
                    sValid_d = 1'b1;
                    sData_d  = in_data;
                    sCtrl_d  = in_ctrl;
                end
            end
        end else begin
            if (inFire) begin
                mValid_d = 1'b1;
                mData_d  = in_data;
                mCtrl_d  = in_ctrl;
            end else if (outFire) begin
                mValid_d = 1'b0;
                mCtrl_d  = '0;
            end
        end
    end

    // Stall statistic for the hazard unit. It counts every cycle where the
    // head waits on downstream. It saturates instead of wrapping so that a
    // long stall never reads as a short one, and only reset clears it.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mValid_q && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mValid_q   <= 1'b0;
            mData_q    <= '0;
            mCtrl_q    <= '0;
            sValid_q   <= 1'b0;
            sData_q    <= '0;
            sCtrl_q    <= '0;
            stallCnt_q <= '0;
        end else begin
            mValid_q   <= mValid_d;
            mData_q    <= mData_d;
            mCtrl_q    <= mCtrl_d;
            sValid_q   <= sValid_d;
            sData_q    <= sData_d;
            sCtrl_q    <= sCtrl_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_ppl_stage_buf.sv
// ---------------------------------------------------------------------------
// Testbench for ppl_stage_buf. It instantiates two copies of the stage:
// dutA uses SKID=1 with a 4-bit stall counter, and dutB uses SKID=0. Each
// copy is tracked by a queue model: accepted entries are pushed, departing
// entries are popped, and a flush empties the queue. The expected outputs
// follow from the queue contents.
// ---------------------------------------------------------------------------
module tb_ppl_stage_buf;

    logic        clk;
    logic        rst;

    logic        aFlush, aInValid, aInReady, aOutValid, aOutReady;
    logic [31:0] aInData, aOutData;
    logic [15:0] aInCtrl, aOutCtrl;
    logic [1:0]  aLevel;
    logic [3:0]  aStallCnt;

    logic        bFlush, bInValid, bInReady, bOutValid, bOutReady;
    logic [31:0] bInData, bOutData;
    logic [15:0] bInCtrl, bOutCtrl;
    logic [1:0]  bLevel;
    logic [15:0] bStallCnt;

    logic [47:0] qA[$];
    logic [47:0] qB[$];
    logic [3:0]  expStallA;
    logic [15:0] expStallB;

    int testsRun;
    int testsFailed;

    ppl_stage_buf #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) dutA (
        .clk(clk), .rst(rst), .flush(aFlush),
        .in_valid(aInValid), .in_ready(aInReady), .in_data(aInData), .in_ctrl(aInCtrl),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData), .out_ctrl(aOutCtrl),
        .level(aLevel), .stall_cnt(aStallCnt)
    );

    ppl_stage_buf #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(16)) dutB (
        .clk(clk), .rst(rst), .flush(bFlush),
        .in_valid(bInValid), .in_ready(bInReady), .in_data(bInData), .in_ctrl(bInCtrl),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData), .out_ctrl(bOutCtrl),
        .level(bLevel), .stall_cnt(bStallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic driveA(input logic v, input logic [31:0] d, input logic [15:0] c,
                          input logic ordy, input logic fl);
        aInValid = v; aInData = d; aInCtrl = c; aOutReady = ordy; aFlush = fl;
    endtask

    task automatic driveB(input logic v, input logic [31:0] d, input logic [15:0] c,
                          input logic ordy, input logic fl);
        bInValid = v; bInData = d; bInCtrl = c; bOutReady = ordy; bFlush = fl;
    endtask

    // Advances one clock and updates both queue models from the inputs that
    // applied during that cycle.
    task automatic clockBoth();
        logic aInF, aOutF, bInF, bOutF;
        logic [47:0] aNew, bNew;
        aInF  = aInValid && (qA.size() < 2);
        aOutF = (qA.size() > 0) && aOutReady;
        bInF  = bInValid && ((qB.size() == 0) || bOutReady);
        bOutF = (qB.size() > 0) && bOutReady;
        aNew  = {aInCtrl, aInData};
        bNew  = {bInCtrl, bInData};
        if (qA.size() > 0 && !aOutReady && expStallA != 4'hF)    expStallA = expStallA + 4'd1;
        if (qB.size() > 0 && !bOutReady && expStallB != 16'hFFFF) expStallB = expStallB + 16'd1;
        @(posedge clk);
        #1;
        if (aFlush) qA.delete();
        else begin
            if (aOutF) void'(qA.pop_front());
            if (aInF)  qA.push_back(aNew);
        end
        if (bFlush) qB.delete();
        else begin
            if (bOutF) void'(qB.pop_front());
            if (bInF)  qB.push_back(bNew);
        end
    endtask

    task automatic test_reset();
        testsRun++; if (aOutValid !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_out_valid got %0b want 0", aOutValid); end
        testsRun++; if (aOutData !== 32'h0)   begin testsFailed++; $display("[TB] FAIL reset_out_data got %h want 0", aOutData); end
        testsRun++; if (aOutCtrl !== 16'h0)   begin testsFailed++; $display("[TB] FAIL reset_out_ctrl got %h want 0", aOutCtrl); end
        testsRun++; if (aLevel !== 2'd0)      begin testsFailed++; $display("[TB] FAIL reset_level got %0d want 0", aLevel); end
        testsRun++; if (aStallCnt !== 4'd0)   begin testsFailed++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", aStallCnt); end
        testsRun++; if (aInReady !== 1'b1)    begin testsFailed++; $display("[TB] FAIL reset_in_ready_skid got %0b want 1", aInReady); end
        testsRun++; if (bInReady !== 1'b1)    begin testsFailed++; $display("[TB] FAIL reset_in_ready_noskid got %0b want 1", bInReady); end
        testsRun++; if (bOutValid !== 1'b0)   begin testsFailed++; $display("[TB] FAIL reset_out_valid_noskid got %0b want 0", bOutValid); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 4; i++) begin
            driveA(i < 3, 32'h100 + 32'(4 * i), 16'h10 + 16'(i), 1'b1, 1'b0);
            @(negedge clk);
            testsRun++; if (aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_in_ready[%0d] got %0b want 1", i, aInReady); end
            testsRun++; if (aLevel !== ((i > 0) ? 2'd1 : 2'd0)) begin testsFailed++; $display("[TB] FAIL stream_level[%0d] got %0d", i, aLevel); end
            testsRun++; if (aOutValid !== (i > 0)) begin testsFailed++; $display("[TB] FAIL stream_out_valid[%0d] got %0b", i, aOutValid); end
            if (i > 0) begin
                testsRun++;
                if (aOutData !== 32'h100 + 32'(4 * (i - 1))) begin
                    testsFailed++; $display("[TB] FAIL stream_out_data[%0d] got %h want %h", i, aOutData, 32'h100 + 32'(4 * (i - 1)));
                end
            end
            clockBoth();
        end
        driveA(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL stream_drained got %0b want 0", aOutValid); end
        clockBoth();
    endtask

    task automatic test_stall_skid();
        driveA(1'b1, 32'h100, 16'h0A, 1'b0, 1'b0);
        clockBoth();
        driveA(1'b1, 32'h104, 16'h0B, 1'b0, 1'b0);
        @(negedge clk);
        testsRun++; if (aLevel !== 2'd1 || aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_pre level %0d in_ready %0b want 1/1", aLevel, aInReady); end
        clockBoth();
        driveA(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        testsRun++; if (aLevel !== 2'd2) begin testsFailed++; $display("[TB] FAIL stall_level got %0d want 2", aLevel); end
        testsRun++; if (aInReady !== 1'b0) begin testsFailed++; $display("[TB] FAIL stall_in_ready got %0b want 0", aInReady); end
        testsRun++; if (aOutData !== 32'h100) begin testsFailed++; $display("[TB] FAIL stall_hold_data got %h want 100", aOutData); end
        clockBoth();
        // This offered entry arrives while in_ready is low and must not be taken.
        driveA(1'b1, 32'hDEAD, 16'h0C, 1'b1, 1'b0);
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b1 || aOutData !== 32'h100 || aOutCtrl !== 16'h0A) begin testsFailed++; $display("[TB] FAIL drain_first got v%0b %h/%h want 1 100/000a", aOutValid, aOutData, aOutCtrl); end
        clockBoth();
        driveA(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b1 || aOutData !== 32'h104 || aOutCtrl !== 16'h0B) begin testsFailed++; $display("[TB] FAIL drain_second got v%0b %h/%h want 1 104/000b", aOutValid, aOutData, aOutCtrl); end
        testsRun++; if (aInReady !== 1'b1 || aLevel !== 2'd1) begin testsFailed++; $display("[TB] FAIL drain_ready got %0b level %0d want 1/1", aInReady, aLevel); end
        clockBoth();
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b0 || aLevel !== 2'd0) begin testsFailed++; $display("[TB] FAIL drain_empty got v%0b level %0d want 0/0", aOutValid, aLevel); end
        testsRun++; if (aStallCnt !== 4'd2) begin testsFailed++; $display("[TB] FAIL stall_count got %0d want 2", aStallCnt); end
        clockBoth();
    endtask

    task automatic test_flush();
        driveA(1'b1, 32'h300, 16'h1, 1'b0, 1'b0);
        clockBoth();
        driveA(1'b1, 32'h304, 16'h2, 1'b0, 1'b0);
        clockBoth();
        driveA(1'b1, 32'hBAD, 16'h3, 1'b0, 1'b1);
        @(negedge clk);
        testsRun++; if (aLevel !== 2'd2) begin testsFailed++; $display("[TB] FAIL flush_setup_level got %0d want 2", aLevel); end
        clockBoth();
        driveA(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b0 || aOutCtrl !== 16'h0) begin testsFailed++; $display("[TB] FAIL flush_out got v%0b ctrl %h want 0/0", aOutValid, aOutCtrl); end
        testsRun++; if (aLevel !== 2'd0 || aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL flush_level got %0d in_ready %0b want 0/1", aLevel, aInReady); end
        testsRun++; if (aStallCnt !== expStallA) begin testsFailed++; $display("[TB] FAIL flush_stall_kept got %0d want %0d", aStallCnt, expStallA); end
        clockBoth();
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_dropped_input got v%0b data %h want 0", aOutValid, aOutData); end
        clockBoth();
    endtask

    task automatic test_bubble_ctrl();
        driveA(1'b1, 32'h55, 16'hFFFF, 1'b1, 1'b0);
        clockBoth();
        driveA(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b1 || aOutCtrl !== 16'hFFFF) begin testsFailed++; $display("[TB] FAIL bubble_load got v%0b ctrl %h want 1/ffff", aOutValid, aOutCtrl); end
        clockBoth();
        @(negedge clk);
        testsRun++; if (aOutValid !== 1'b0 || aOutCtrl !== 16'h0000) begin testsFailed++; $display("[TB] FAIL bubble_ctrl got v%0b ctrl %h want 0/0000", aOutValid, aOutCtrl); end
        clockBoth();
    endtask

    task automatic test_saturation_and_reset();
        driveA(1'b1, 32'h400, 16'h7, 1'b0, 1'b0);
        clockBoth();
        driveA(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) clockBoth();
        @(negedge clk);
        testsRun++; if (aStallCnt !== 4'd15) begin testsFailed++; $display("[TB] FAIL stall_saturate got %0d want 15", aStallCnt); end
        testsRun++; if (aOutValid !== 1'b1 || aOutData !== 32'h400) begin testsFailed++; $display("[TB] FAIL stall_hold got v%0b %h want 1/400", aOutValid, aOutData); end
        // Asynchronous reset between clock edges.
        rst = 1'b1;
        #1;
        testsRun++; if (aOutValid !== 1'b0 || aOutData !== 32'h0 || aOutCtrl !== 16'h0) begin testsFailed++; $display("[TB] FAIL async_rst_out got v%0b %h/%h want 0", aOutValid, aOutData, aOutCtrl); end
        testsRun++; if (aStallCnt !== 4'd0 || aLevel !== 2'd0 || aInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL async_rst_state cnt %0d level %0d rdy %0b", aStallCnt, aLevel, aInReady); end
        #1;
        rst = 1'b0;
        qA.delete(); qB.delete();
        expStallA = '0; expStallB = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random_skid();
        for (int i = 0; i < 400; i++) begin
            driveA(($urandom_range(0, 3) != 0), $urandom, 16'($urandom),
                   ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
            @(negedge clk);
            testsRun++;
            if (aOutValid !== (qA.size() > 0) || aLevel !== 2'(qA.size()) || aInReady !== (qA.size() < 2)
                || aStallCnt !== expStallA
                || aOutCtrl !== ((qA.size() > 0) ? qA[0][47:32] : 16'h0)
                || ((qA.size() > 0) && aOutData !== qA[0][31:0])) begin
                testsFailed++;
                $display("[TB] FAIL rand_skid[%0d] got v%0b d%h c%h lv%0d rdy%0b cnt%0d, model size %0d cnt %0d",
                         i, aOutValid, aOutData, aOutCtrl, aLevel, aInReady, aStallCnt, qA.size(), expStallA);
            end
            clockBoth();
        end
        driveA(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    endtask

    task automatic test_noskid();
        driveB(1'b1, 32'h200, 16'h1, 1'b0, 1'b0);
        clockBoth();
        driveB(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        testsRun++; if (bInReady !== 1'b0 || bLevel !== 2'd1) begin testsFailed++; $display("[TB] FAIL noskid_stall rdy %0b level %0d want 0/1", bInReady, bLevel); end
        bOutReady = 1'b1;
        #1;
        testsRun++; if (bInReady !== 1'b1) begin testsFailed++; $display("[TB] FAIL noskid_comb_ready got %0b want 1", bInReady); end
        driveB(1'b1, 32'h204, 16'h2, 1'b1, 1'b0);
        clockBoth();
        driveB(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
        @(negedge clk);
        testsRun++; if (bOutValid !== 1'b1 || bOutData !== 32'h204 || bOutCtrl !== 16'h2 || bLevel !== 2'd1) begin testsFailed++; $display("[TB] FAIL noskid_replace got v%0b %h/%h lv%0d want 1 204/0002 1", bOutValid, bOutData, bOutCtrl, bLevel); end
        clockBoth();
        @(negedge clk);
        testsRun++; if (bOutValid !== 1'b0 || bOutCtrl !== 16'h0) begin testsFailed++; $display("[TB] FAIL noskid_drain got v%0b ctrl %h want 0", bOutValid, bOutCtrl); end
        clockBoth();
    endtask

    task automatic test_random_noskid();
        for (int i = 0; i < 300; i++) begin
            driveB(($urandom_range(0, 3) != 0), $urandom, 16'($urandom),
                   ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
            @(negedge clk);
            testsRun++;
            if (bOutValid !== (qB.size() > 0) || bLevel !== 2'(qB.size())
                || bInReady !== ((qB.size() == 0) || bOutReady)
                || bStallCnt !== expStallB
                || bOutCtrl !== ((qB.size() > 0) ? qB[0][47:32] : 16'h0)
                || ((qB.size() > 0) && bOutData !== qB[0][31:0])) begin
                testsFailed++;
                $display("[TB] FAIL rand_noskid[%0d] got v%0b d%h c%h lv%0d rdy%0b cnt%0d, model size %0d cnt %0d",
                         i, bOutValid, bOutData, bOutCtrl, bLevel, bInReady, bStallCnt, qB.size(), expStallB);
            end
            clockBoth();
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expStallA   = '0;
        expStallB   = '0;
        rst = 1'b1;
        driveA(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        driveB(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
        #2;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_streaming();
        test_stall_skid();
        test_flush();
        test_bubble_ctrl();
        test_saturation_and_reset();
        test_random_skid();
        test_noskid();
        test_random_noskid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/ppl_stage_buf.md
Name: ppl_stage_buf

Overview:
- Parametrised pipeline stage register for the in-order core. It is the generalised successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM).
- Carries an opaque data bundle and a control bundle with a valid/ready handshake.
- Stall holds the stage contents instead of zeroing them. A separate flush squashes the stage.
- Optional 2-entry skid buffer registers in_ready so it breaks the backward stall path. Occupancy and stall-cycle statistics are exposed for the hazard unit and debug.

Parameters:
- DATA_W, 32: width of data bundle (PC, operands, immediate).
- CTRL_W, 16: width of control bundle (RegWe, mem_ctrl, JUMPop, ...). Cleared on bubble or flush.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: width of stall-cycle counter.

Ports:
- clk  in  1  stage clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  squash all held entries (branch or interrupt redirect).
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head; 0 = hold (stall).
- out_data  out  DATA_W  head data.
- out_ctrl  out  CTRL_W  head control; forced 0 whenever out_valid=0.
- level  out  2  entries held (0..2; max 1 when SKID=0).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Storage is a main entry M (drives outputs) plus, if SKID=1, a skid entry S. Each entry has valid, data and ctrl.
- Reset (async, rst=1):
  - M and S valid=0, data=0, ctrl=0.
  - out_valid=0, out_data=0, out_ctrl=0, level=0, stall_cnt=0.
  - in_ready=1 when SKID=1; in_ready=1 when SKID=0, since it follows M_valid=0.
  - Deassertion takes effect at the next clk edge.
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Data/ctrl are sampled only on in_fire. in_data/in_ctrl are don't-care otherwise.
- in_ready:
  - SKID=1: in_ready = ~S_valid. Registered, no combinational path from out_ready.
  - SKID=0: in_ready = ~M_valid | out_ready (combinational).
- Latency: 1 cycle from in_fire to out_valid when M is empty or draining. Throughput is 1 entry/cycle with out_ready held high.
- Per-edge update when flush=0, SKID=1:
  - out_fire & S_valid: M<=S; S invalid, ctrl 0. If in_fire in the same cycle, that cannot happen because in_ready=0.
  - out_fire & ~S_valid & in_fire: M<=in.
  - out_fire & ~S_valid & ~in_fire: M_valid<=0, M_ctrl<=0, M_data held.
  - ~out_fire & in_fire & ~M_valid: M<=in.
  - ~out_fire & in_fire & M_valid: S<=in. This is the skid capture, so in_ready falls next cycle.
  - ~out_fire & ~in_fire: hold everything.
- SKID=0 update:
  - in_fire: M<=in.
  - else out_fire: M_valid<=0, M_ctrl<=0.
  - else hold.
- Flush:
  - Has priority over all handshakes in the same cycle.
  - M and S valid<=0, ctrl<=0; data held.
  - Any in_fire in the flush cycle is dropped. out_fire in the flush cycle still completes downstream.
  - Next cycle: level=0, in_ready=1.
- Invariants:
  - out_ctrl==0 whenever out_valid==0, so bubbles carry no side effects.
  - S_valid implies M_valid.
  - level = M_valid + S_valid, registered.
- stall_cnt:
  - +1 per cycle with out_valid & ~out_ready.
  - Saturates at all-ones, no wrap.
  - Cleared only by rst; flush does not clear it.
- Order preservation: entries leave in acceptance order. No entry is duplicated or lost except by flush.

Test Plan:
- Streaming: SKID=1, out_ready=1, inject data 0x100,0x104,0x108 on consecutive cycles → out_valid each cycle from cycle+1, same order, level≤1, in_ready stays 1.
- Stall with skid: M holds 0x100; drop out_ready; inject 0x104 → S captures 0x104, level=2, in_ready=0 next cycle. Raise out_ready → 0x100 then 0x104 emerge on consecutive cycles, in_ready=1 after S drains. stall_cnt counts exactly the stalled cycles.
- Flush priority: level=2, in_valid=1, flush=1 with out_ready=0 → next cycle out_valid=0, out_ctrl=0, level=0, in_ready=1; the flushed-cycle input never appears.
- Bubble ctrl clear: ctrl=0xFFFF entry drains with no new input → out_valid=0 and out_ctrl=0x0000 the following cycle.
- Counter saturation: CNT_W=4, stall 20 cycles → stall_cnt=15 and holds. Async rst mid-stall (between edges) → all outputs zero immediately, stall_cnt=0.
- SKID=0: out_ready=0 with M valid → in_ready=0 same cycle. out_ready=1 with simultaneous in_valid → replace in one cycle, level stays 1.
